// File: rtl/dm_lsu_if.sv
// dm_lsu_if: groups the datapath request/response handshake and the
// word-wide data memory bus of the load/store unit.
//   request : req, st, size, uns, addr, wdata   (datapath -> lsu)
//   response: ready, done, err, rdata           (lsu -> datapath)
//   memory  : mem_addr, mem_din, mem_we (lsu -> mem), mem_dout (mem -> lsu)
// slave  = the LSU side, master = the datapath/memory environment side.
interface dm_lsu_if #(
  parameter int unsigned ADDR_W = 10
) ();

  logic              req;
  logic              st;
  logic [1:0]        size;
  logic              uns;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       wdata;

  logic              ready;
  logic              done;
  logic              err;
  logic [31:0]       rdata;

  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_din;
  logic              mem_we;
  logic [31:0]       mem_dout;

  modport slave (
    input  req, st, size, uns, addr, wdata, mem_dout,
    output ready, done, err, rdata, mem_addr, mem_din, mem_we
  );

  modport master (
    output req, st, size, uns, addr, wdata, mem_dout,
    input  ready, done, err, rdata, mem_addr, mem_din, mem_we
  );

endinterface

// File: rtl/dm_lsu.sv
// dm_lsu: single-outstanding load/store initiator for a byte-addressed,
// little-endian, word-wide data memory. Issues word-aligned accesses,
// performs read-modify-write for byte/halfword stores, extracts and
// sign/zero-extends load lanes, and rejects misaligned requests with err.
// Ports:
//   clk    rising-edge clock
//   rst_n  synchronous active-low reset
//   bus    dm_lsu_if.slave (request, response and memory bus signals)
module dm_lsu #(
  parameter int unsigned ADDR_W = 10
) (
  input  logic    clk,
  input  logic    rst_n,
  dm_lsu_if.slave bus
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_RMW   = 2'd2;
  localparam logic [1:0] S_WRITE = 2'd3;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  logic [1:0]        state_q, state_d;
  logic [1:0]        size_q,  size_d;
  logic              uns_q,   uns_d;
  logic [ADDR_W-1:0] addr_q,  addr_d;
  logic [31:0]       din_q,   din_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              done_q,  done_d;
  logic              err_q,   err_d;

  logic              misalign_c;
  logic [7:0]        lane_b_c;
  logic [15:0]       lane_h_c;
  logic [31:0]       load_c;
  logic [31:0]       merge_c;

  // Alignment check on the incoming request (evaluated in IDLE only)
  always_comb begin
    case (bus.size)
      SZ_BYTE: misalign_c = 1'b0;
      SZ_HALF: misalign_c = bus.addr[0];
      SZ_WORD: misalign_c = (bus.addr[1:0] != 2'b00);
      default: misalign_c = 1'b1;
    endcase
  end

  // Load lane extraction and extension from the current memory word
  always_comb begin
    case (addr_q[1:0])
      2'd0:    lane_b_c = bus.mem_dout[7:0];
      2'd1:    lane_b_c = bus.mem_dout[15:8];
      2'd2:    lane_b_c = bus.mem_dout[23:16];
      default: lane_b_c = bus.mem_dout[31:24];
    endcase
    lane_h_c = addr_q[1] ? bus.mem_dout[31:16] : bus.mem_dout[15:0];
    case (size_q)
      SZ_BYTE: load_c = {{24{~uns_q & lane_b_c[7]}}, lane_b_c};
      SZ_HALF: load_c = {{16{~uns_q & lane_h_c[15]}}, lane_h_c};
      default: load_c = bus.mem_dout;
    endcase
  end

  // Sub-word store merge: din_q still holds the right-justified store data
  always_comb begin
    merge_c = bus.mem_dout;
    if (size_q == SZ_BYTE) begin
      case (addr_q[1:0])
        2'd0:    merge_c[7:0]   = din_q[7:0];
        2'd1:    merge_c[15:8]  = din_q[7:0];
        2'd2:    merge_c[23:16] = din_q[7:0];
        default: merge_c[31:24] = din_q[7:0];
      endcase
    end else if (addr_q[1]) begin
      merge_c[31:16] = din_q[15:0];
    end else begin
      merge_c[15:0]  = din_q[15:0];
    end
  end

  // Next-state and register-input logic
  always_comb begin
    state_d = state_q;
    size_d  = size_q;
    uns_d   = uns_q;
    addr_d  = addr_q;
    din_d   = din_q;
    rdata_d = rdata_q;
    done_d  = 1'b0;
    err_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.req) begin
          size_d = bus.size;
          uns_d  = bus.uns;
          addr_d = bus.addr;
          din_d  = bus.wdata;
          if (misalign_c) begin
            done_d = 1'b1;
            err_d  = 1'b1;
          end else if (!bus.st) begin
            state_d = S_LOAD;
          end else if (bus.size == SZ_WORD) begin
            state_d = S_WRITE;
          end else begin
            state_d = S_RMW;
          end
        end
      end
      S_LOAD: begin
        rdata_d = load_c;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      S_RMW: begin
        din_d   = merge_c;
        state_d = S_WRITE;
      end
      default: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers, synchronous reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      size_q  <= 2'b00;
      uns_q   <= 1'b0;
      addr_q  <= '0;
      din_q   <= 32'h0;
      rdata_q <= 32'h0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
      rdata_q <= rdata_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign bus.ready    = (state_q == S_IDLE);
  assign bus.done     = done_q;
  assign bus.err      = err_q;
  assign bus.rdata    = rdata_q;
  assign bus.mem_addr = {addr_q[ADDR_W-1:2], 2'b00};
  assign bus.mem_din  = din_q;
  // Gating with rst_n drops a write that is in flight when reset arrives
  assign bus.mem_we   = (state_q == S_WRITE) & rst_n;

endmodule

// File: tb/tb_dm_lsu.sv
// tb_dm_lsu: directed bench for dm_lsu with a byte-array memory, a
// transaction-level reference model and a per-cycle output comparator.
module tb_dm_lsu;

  localparam int unsigned ADDR_W = 10;
  localparam int          MEM_B  = 1 << ADDR_W;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  dm_lsu_if #(.ADDR_W(ADDR_W)) bus ();

  dm_lsu #(.ADDR_W(ADDR_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Physical memory seen by the DUT
  logic [7:0] ram [0:MEM_B-1];
  assign bus.mem_dout = {ram[int'(bus.mem_addr) + 3], ram[int'(bus.mem_addr) + 2],
                         ram[int'(bus.mem_addr) + 1], ram[int'(bus.mem_addr)]};
  always @(posedge clk) begin
    if (bus.mem_we) begin
      for (int i = 0; i < 4; i++) ram[int'(bus.mem_addr) + i] <= bus.mem_din[8*i +: 8];
    end
  end

  // Reference memory, updated only by the model
  logic [7:0] ref_mem [0:MEM_B-1];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  // Expectation for the transaction in flight (cycle numbers = value of cyc)
  int          e_acc   = -1;
  int          e_done  = -1;
  bit          e_err   = 1'b0;
  bit          e_st    = 1'b0;
  int          e_waddr = 0;
  logic [31:0] e_load  = 32'h0;
  logic [31:0] e_din   = 32'h0;
  logic [31:0] e_rdata = 32'h0;

  int          we_cnt   = 0;
  logic [31:0] last_din = 32'h0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] ref_word(input int a);
    return {ref_mem[a + 3], ref_mem[a + 2], ref_mem[a + 1], ref_mem[a]};
  endfunction

  function automatic logic [31:0] ref_load(input logic [1:0] size, input logic uns, input int a);
    logic [31:0] v;
    if (size == 2'b00) begin
      v = {24'h0, ref_mem[a]};
      if (!uns && v[7]) v = v | 32'hFFFF_FF00;
    end else if (size == 2'b01) begin
      v = {16'h0, ref_mem[a + 1], ref_mem[a]};
      if (!uns && v[15]) v = v | 32'hFFFF_0000;
    end else begin
      v = ref_word(a);
    end
    return v;
  endfunction

  task automatic ref_store(input logic [1:0] size, input int a, input logic [31:0] wd);
    int n;
    n = (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
    for (int i = 0; i < n; i++) ref_mem[a + i] = wd[8*i +: 8];
  endtask

  // Per-cycle comparator against the model expectations
  always @(negedge clk) begin
    if (chk_en) begin
      bit busy, dn, we;
      busy = (e_acc >= 0) && (cyc >= e_acc) && (cyc < e_done);
      dn   = (e_done >= 0) && (cyc == e_done);
      we   = e_st && !e_err && (e_done >= 0) && (cyc == e_done - 1) && rst_n;
      if (dn && !e_st && !e_err) e_rdata = e_load;
      chk("ready",  32'(bus.ready),  32'(!busy));
      chk("done",   32'(bus.done),   32'(dn));
      chk("err",    32'(bus.err),    32'(dn && e_err));
      chk("mem_we", 32'(bus.mem_we), 32'(we));
      chk("rdata",  bus.rdata,       e_rdata);
      if (busy) chk("mem_addr", 32'(bus.mem_addr), 32'(e_waddr));
      if (we)   chk("mem_din",  bus.mem_din,       e_din);
      if (bus.mem_we) begin
        we_cnt++;
        last_din = bus.mem_din;
      end
    end
  end

  // Issue one request (called at posedge+1); returns in the done cycle
  task automatic do_req(input logic st, input logic [1:0] size, input logic uns,
                        input int addr, input logic [31:0] wd, input bit pulse);
    bit mis;
    bus.req   = 1'b1;
    bus.st    = st;
    bus.size  = size;
    bus.uns   = uns;
    bus.addr  = ADDR_W'(addr);
    bus.wdata = wd;
    @(posedge clk); #1;
    mis = (size == 2'b11) || (size == 2'b01 && (addr % 2) != 0) ||
          (size == 2'b10 && (addr % 4) != 0);
    e_acc   = cyc;
    e_err   = mis;
    e_st    = st;
    e_waddr = addr - (addr % 4);
    if (mis)                         e_done = cyc;
    else if (!st || size == 2'b10)   e_done = cyc + 1;
    else                             e_done = cyc + 2;
    if (!mis) begin
      if (st) begin
        ref_store(size, addr, wd);
        e_din = ref_word(e_waddr);
      end else begin
        e_load = ref_load(size, uns, addr);
      end
    end
    if (pulse) begin
      // Misaligned LW while busy: would raise err if it were accepted
      bus.st   = 1'b0;
      bus.size = 2'b10;
      bus.addr = ADDR_W'(6);
      @(posedge clk); #1;
    end
    bus.req = 1'b0;
    while (cyc < e_done) begin
      @(posedge clk); #1;
    end
  endtask

  // Byte store whose WRITE cycle is hit by reset
  task automatic sb_abort(input int addr, input logic [7:0] b);
    bus.req   = 1'b1;
    bus.st    = 1'b1;
    bus.size  = 2'b00;
    bus.uns   = 1'b0;
    bus.addr  = ADDR_W'(addr);
    bus.wdata = {24'h0, b};
    @(posedge clk); #1;
    e_acc = cyc; e_done = cyc + 2; e_err = 1'b0; e_st = 1'b1;
    e_waddr = addr - (addr % 4);
    bus.req = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    e_acc = -1; e_done = -1; e_st = 1'b0; e_rdata = 32'h0;
    rst_n = 1'b1;
    chk("abort_ready",    32'(bus.ready),    32'h1);
    chk("abort_done",     32'(bus.done),     32'h0);
    chk("abort_err",      32'(bus.err),      32'h0);
    chk("abort_rdata",    bus.rdata,         32'h0);
    chk("abort_mem_addr", 32'(bus.mem_addr), 32'h0);
    chk("abort_mem_din",  bus.mem_din,       32'h0);
    chk("abort_mem_we",   32'(bus.mem_we),   32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int w0;
    for (int i = 0; i < MEM_B; i++) begin
      ram[i]     = 8'(i * 7 + 3);
      ref_mem[i] = 8'(i * 7 + 3);
    end
    rst_n = 1'b0;
    bus.req = 1'b0; bus.st = 1'b0; bus.size = 2'b00; bus.uns = 1'b0;
    bus.addr = '0; bus.wdata = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    rst_n  = 1'b1;
    chk_en = 1'b1;
    chk("rst_ready",    32'(bus.ready),    32'h1);
    chk("rst_done",     32'(bus.done),     32'h0);
    chk("rst_err",      32'(bus.err),      32'h0);
    chk("rst_rdata",    bus.rdata,         32'h0);
    chk("rst_mem_addr", 32'(bus.mem_addr), 32'h0);
    chk("rst_mem_din",  bus.mem_din,       32'h0);
    chk("rst_mem_we",   32'(bus.mem_we),   32'h0);

    // Word store then load
    w0 = we_cnt;
    do_req(1'b1, 2'b10, 1'b0, 'h008, 32'h8899AABB, 1'b0);
    chk("sw_we_count", 32'(we_cnt - w0), 32'h1);
    do_req(1'b0, 2'b10, 1'b0, 'h008, 32'h0, 1'b0);
    chk("lw_8", bus.rdata, 32'h8899AABB);

    // Sub-word loads
    do_req(1'b0, 2'b00, 1'b0, 'h00B, 32'h0, 1'b0);  chk("lb_b",  bus.rdata, 32'hFFFFFF88);
    do_req(1'b0, 2'b00, 1'b1, 'h00B, 32'h0, 1'b0);  chk("lbu_b", bus.rdata, 32'h00000088);
    do_req(1'b0, 2'b01, 1'b0, 'h00A, 32'h0, 1'b0);  chk("lh_a",  bus.rdata, 32'hFFFF8899);
    do_req(1'b0, 2'b01, 1'b1, 'h008, 32'h0, 1'b0);  chk("lhu_8", bus.rdata, 32'h0000AABB);
    do_req(1'b0, 2'b00, 1'b0, 'h008, 32'h0, 1'b0);  chk("lb_8",  bus.rdata, 32'hFFFFFFBB);

    // Sub-word stores, with a req pulse during RMW
    w0 = we_cnt;
    do_req(1'b1, 2'b00, 1'b0, 'h009, 32'h0000005A, 1'b1);
    chk("sb_we_count", 32'(we_cnt - w0), 32'h1);
    chk("sb_din", last_din, 32'h88995ABB);
    do_req(1'b0, 2'b10, 1'b0, 'h008, 32'h0, 1'b0);  chk("lw_after_sb", bus.rdata, 32'h88995ABB);
    do_req(1'b1, 2'b01, 1'b0, 'h00A, 32'h00001234, 1'b0);
    do_req(1'b0, 2'b10, 1'b0, 'h008, 32'h0, 1'b0);  chk("lw_after_sh", bus.rdata, 32'h12345ABB);

    // Misaligned requests
    w0 = we_cnt;
    do_req(1'b0, 2'b10, 1'b0, 'h006, 32'h0, 1'b0);
    chk("mis_lw_done", 32'(bus.done), 32'h1);
    chk("mis_lw_err",  32'(bus.err),  32'h1);
    do_req(1'b1, 2'b01, 1'b0, 'h001, 32'h0000BEEF, 1'b0);
    chk("mis_sh_err",  32'(bus.err),  32'h1);
    do_req(1'b0, 2'b11, 1'b0, 'h010, 32'h0, 1'b0);
    chk("mis_sz3_err", 32'(bus.err),  32'h1);
    @(posedge clk); #1;
    chk("mis_rdata_kept", bus.rdata, 32'h12345ABB);
    chk("mis_we_count",   32'(we_cnt - w0), 32'h0);

    // Reset during WRITE of SB 0xFF at 0x008
    sb_abort('h008, 8'hFF);
    do_req(1'b0, 2'b10, 1'b0, 'h008, 32'h0, 1'b0);  chk("lw_after_abort", bus.rdata, 32'h12345ABB);

    // Top of memory
    do_req(1'b1, 2'b10, 1'b0, 'h3FC, 32'hDEADBEEF, 1'b0);
    chk("top_mem_addr", 32'(bus.mem_addr), 32'h000003FC);
    do_req(1'b0, 2'b10, 1'b0, 'h3FC, 32'h0, 1'b0);  chk("lw_top", bus.rdata, 32'hDEADBEEF);

    // Lane coverage on word 0x020
    do_req(1'b1, 2'b10, 1'b0, 'h020, 32'h01234567, 1'b0);
    do_req(1'b1, 2'b00, 1'b0, 'h023, 32'h00000080, 1'b0);
    do_req(1'b1, 2'b01, 1'b0, 'h020, 32'h0000FEDC, 1'b0);
    do_req(1'b0, 2'b01, 1'b0, 'h022, 32'h0, 1'b0);  chk("lh_22",  bus.rdata, 32'hFFFF8023);
    do_req(1'b0, 2'b01, 1'b1, 'h020, 32'h0, 1'b0);  chk("lhu_20", bus.rdata, 32'h0000FEDC);
    do_req(1'b0, 2'b00, 1'b1, 'h021, 32'h0, 1'b0);  chk("lbu_21", bus.rdata, 32'h000000FE);
    do_req(1'b0, 2'b00, 1'b0, 'h022, 32'h0, 1'b0);
    do_req(1'b1, 2'b00, 1'b0, 'h022, 32'h000000C3, 1'b0);
    do_req(1'b0, 2'b10, 1'b0, 'h020, 32'h0, 1'b0);  chk("lw_20", bus.rdata, 32'h80C3FEDC);

    repeat (3) @(posedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
